debounce_botao: RTL and testbench

DEBOUNCE_BOTAO -- requirements
Module: debounce_botao

---
 rtl/pkg_mastermind.sv | 19 +
 rtl/sincronizador_2ff.sv | 22 ++
 rtl/debounce_botao.sv | 98 +++++++++
 tb/tb_debounce_botao.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pkg_mastermind.sv
// Constants and types shared by the Mastermind game blocks.
// Debounce FSM encoding and the default confirmation length.
package pkg_mastermind;

   localparam int unsigned N_DEBOUNCE_PAD = 4;

   typedef enum logic [1:0] {
      SOLTO        = 2'b00,
      CONF_APERTO  = 2'b01,
      APERTADO     = 2'b10,
      CONF_SOLTURA = 2'b11
   } estado_botao_t;

   // Counter width for a count 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_largura(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reusable for every game button.
module sincronizador_2ff (
   input  logic CLK,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/debounce_botao.sv
// Push-button debouncer: synchronizes the raw pin, confirms level changes
// over N_DEBOUNCE samples, and emits one pulse per confirmed press.
module debounce_botao
   import pkg_mastermind::*;
#(
   parameter int unsigned N_DEBOUNCE  = N_DEBOUNCE_PAD,
   parameter bit          ATIVO_BAIXO = 1'b0
) (
   input  logic CLK,
   input  logic rst,
   input  logic botao_bruto,
   output logic botao,
   output logic estavel
);

   localparam int unsigned       CNT_W   = cnt_largura(N_DEBOUNCE);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N_DEBOUNCE - 1);

   logic             bruto_ativo_c;
   logic             sinc;
   estado_botao_t    estado, estado_prox;
   logic [CNT_W-1:0] cnt, cnt_prox;
   logic             botao_prox, estavel_prox;

   assign bruto_ativo_c = ATIVO_BAIXO ? ~botao_bruto : botao_bruto;

   sincronizador_2ff u_sinc (
      .CLK (CLK),
      .rst (rst),
      .d   (bruto_ativo_c),
      .q   (sinc)
   );

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         estado  <= SOLTO;
         cnt     <= '0;
         botao   <= 1'b0;
         estavel <= 1'b0;
      end else begin
         estado  <= estado_prox;
         cnt     <= cnt_prox;
         botao   <= botao_prox;
         estavel <= estavel_prox;
      end
   end

   // Outputs are derived from the next state so they align with the state register.
   always_comb begin
      estado_prox  = estado;
      cnt_prox     = cnt;
      botao_prox   = 1'b0;
      estavel_prox = 1'b0;
      case (estado)
         SOLTO: begin
            if (sinc) begin
               estado_prox = CONF_APERTO;
               cnt_prox    = '0;
            end
         end
         CONF_APERTO: begin
            if (!sinc) begin
               estado_prox = SOLTO;
               cnt_prox    = '0;
            end else if (cnt == CNT_MAX) begin
               estado_prox = APERTADO;
               cnt_prox    = '0;
               botao_prox  = 1'b1;
            end else begin
               cnt_prox = cnt + CNT_W'(1);
            end
         end
         APERTADO: begin
            if (!sinc) begin
               estado_prox = CONF_SOLTURA;
               cnt_prox    = '0;
            end
         end
         CONF_SOLTURA: begin
            if (sinc) begin
               estado_prox = APERTADO;
               cnt_prox    = '0;
            end else if (cnt == CNT_MAX) begin
               estado_prox = SOLTO;
               cnt_prox    = '0;
            end else begin
               cnt_prox = cnt + CNT_W'(1);
            end
         end
         default: begin
            estado_prox = SOLTO;
            cnt_prox    = '0;
         end
      endcase
      estavel_prox = (estado_prox == APERTADO) || (estado_prox == CONF_SOLTURA);
   end

endmodule

// File: tb/tb_debounce_botao.sv
// Bench for debounce_botao: active-high and active-low instances share one
// stimulus; a run-length reference model feeds a per-cycle scoreboard.
module tb_debounce_botao;

   localparam int N = 4;

   logic CLK   = 1'b0;
   logic rst   = 1'b0;
   logic bruto = 1'b0;
   logic bruto_n;
   logic botao0, estavel0, botao1, estavel1;

   assign bruto_n = ~bruto;

   debounce_botao #(.N_DEBOUNCE(N), .ATIVO_BAIXO(1'b0)) u_alto (
      .CLK(CLK), .rst(rst), .botao_bruto(bruto), .botao(botao0), .estavel(estavel0));

   debounce_botao #(.N_DEBOUNCE(N), .ATIVO_BAIXO(1'b1)) u_baixo (
      .CLK(CLK), .rst(rst), .botao_bruto(bruto_n), .botao(botao1), .estavel(estavel1));

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: a level flips after N+1 consecutive opposite samples.
   logic [1:0] m_p1 = '0, m_p2 = '0, m_stab = '0;
   int         m_run [2] = '{0, 0};
   logic [3:0] sb [$];
   logic       started = 1'b0;

   always @(posedge CLK or posedge rst) begin
      logic [1:0] mb;
      logic [1:0] raw_ativo;
      if (rst) begin
         m_p1 = '0; m_p2 = '0; m_stab = '0;
         m_run[0] = 0; m_run[1] = 0;
         sb.delete();
      end else begin
         raw_ativo = {~bruto_n, bruto};
         for (int i = 0; i < 2; i++) begin
            mb[i] = 1'b0;
            if (m_p2[i] != m_stab[i]) begin
               m_run[i]++;
               if (m_run[i] == N + 1) begin
                  m_stab[i] = ~m_stab[i];
                  mb[i]     = m_stab[i];
                  m_run[i]  = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_p2 = m_p1;
         m_p1 = raw_ativo;
         sb.push_back({mb[1], m_stab[1], mb[0], m_stab[0]});
      end
   end

   int edge_n = 0;
   always @(posedge CLK) edge_n++;

   int   pulses0 = 0, pulses1 = 0, pedge0 = 0, pedge1 = 0;
   int   rises0 = 0, rises1 = 0, falls0 = 0, falls1 = 0, fedge0 = 0, fedge1 = 0;
   logic prev0 = 1'b0, prev1 = 1'b0;

   always @(negedge CLK) begin
      logic [3:0] e;
      if (started) begin
         if (rst) begin
            check_eq("rst_botao0", botao0, 0);
            check_eq("rst_estavel0", estavel0, 0);
            check_eq("rst_botao1", botao1, 0);
            check_eq("rst_estavel1", estavel1, 0);
         end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("sb_botao0", botao0, e[1]);
            check_eq("sb_estavel0", estavel0, e[0]);
            check_eq("sb_botao1", botao1, e[3]);
            check_eq("sb_estavel1", estavel1, e[2]);
         end
         if (!rst) begin
            if (botao0) begin pulses0++; pedge0 = edge_n; end
            if (botao1) begin pulses1++; pedge1 = edge_n; end
            if (!prev0 && estavel0) rises0++;
            if (!prev1 && estavel1) rises1++;
            if (prev0 && !estavel0) begin falls0++; fedge0 = edge_n; end
            if (prev1 && !estavel1) begin falls1++; fedge1 = edge_n; end
         end
         prev0 = estavel0;
         prev1 = estavel1;
      end
   end

   // Drive a level, then advance n edges; always returns 2 time units after an edge.
   task automatic hold(input logic v, input int n);
      bruto = v;
      repeat (n) @(posedge CLK);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b, p0, p1, f0, f1, r0, r1;
      #2 rst = 1'b1;
      #1 started = 1'b1;
      check_eq("reset_botao", {botao1, botao0}, 0);
      check_eq("reset_estavel", {estavel1, estavel0}, 0);
      repeat (3) @(posedge CLK);
      #2 rst = 1'b0;
      hold(1'b0, 5);

      // clean press
      b = edge_n; p0 = pulses0; p1 = pulses1;
      hold(1'b1, 20);
      check_eq("clean_pulses0", pulses0 - p0, 1);
      check_eq("clean_pulses1", pulses1 - p1, 1);
      check_eq("clean_edge0", pedge0 - b, 7);
      check_eq("clean_edge1", pedge1 - b, 7);
      check_eq("clean_estavel", {estavel1, estavel0}, 2'b11);

      // clean release
      b = edge_n; f0 = falls0; f1 = falls1;
      hold(1'b0, 15);
      check_eq("release_falls0", falls0 - f0, 1);
      check_eq("release_falls1", falls1 - f1, 1);
      check_eq("release_edge0", fedge0 - b, 7);
      check_eq("release_edge1", fedge1 - b, 7);

      // short glitch
      p0 = pulses0; p1 = pulses1; r0 = rises0; r1 = rises1;
      hold(1'b1, 3);
      hold(1'b0, 12);
      check_eq("glitch_pulses", (pulses0 - p0) + (pulses1 - p1), 0);
      check_eq("glitch_rises", (rises0 - r0) + (rises1 - r1), 0);

      // press bounce
      p0 = pulses0; p1 = pulses1;
      hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
      b = edge_n;
      hold(1'b1, 15);
      check_eq("bounce_pulses0", pulses0 - p0, 1);
      check_eq("bounce_pulses1", pulses1 - p1, 1);
      check_eq("bounce_edge0", pedge0 - b, 7);
      check_eq("bounce_edge1", pedge1 - b, 7);

      // release bounce
      p0 = pulses0; p1 = pulses1; f0 = falls0; f1 = falls1;
      repeat (3) begin
         hold(1'b0, 2);
         hold(1'b1, 4);
      end
      check_eq("relbounce_falls", (falls0 - f0) + (falls1 - f1), 0);
      check_eq("relbounce_pulses", (pulses0 - p0) + (pulses1 - p1), 0);
      check_eq("relbounce_estavel", {estavel1, estavel0}, 2'b11);
      b = edge_n;
      hold(1'b0, 15);
      check_eq("relbounce_edge0", fedge0 - b, 7);
      check_eq("relbounce_edge1", fedge1 - b, 7);

      // reset mid-confirmation, button kept held
      p0 = pulses0; p1 = pulses1;
      hold(1'b1, 5);
      rst = 1'b1;
      #1;
      check_eq("midrst_botao", {botao1, botao0}, 0);
      check_eq("midrst_estavel", {estavel1, estavel0}, 0);
      @(posedge CLK);
      #2 rst = 1'b0;
      b = edge_n;
      hold(1'b1, 12);
      check_eq("midrst_pulses0", pulses0 - p0, 1);
      check_eq("midrst_pulses1", pulses1 - p1, 1);
      check_eq("midrst_edge0", pedge0 - b, 7);
      check_eq("midrst_edge1", pedge1 - b, 7);

      // reset while pressed clears the level at once
      rst = 1'b1;
      #1;
      check_eq("heldrst_estavel", {estavel1, estavel0}, 0);
      @(posedge CLK);
      #2 rst = 1'b0;
      hold(1'b1, 10);
      hold(1'b0, 15);

      // repeated press/release cycles
      p0 = pulses0; p1 = pulses1;
      repeat (4) begin
         hold(1'b1, 10);
         hold(1'b0, 10);
      end
      check_eq("cycles_pulses0", pulses0 - p0, 4);
      check_eq("cycles_pulses1", pulses1 - p1, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
